// File: rtl/pc_defs.sv
// Shared encodings for the PC fetch unit: next-PC select codes, FSM states
// and the default reset vector.
package pc_defs;
   localparam logic [1:0] NPC_SEQ = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0020;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch request bus between the PC unit (master) and instruction memory (slave).
interface pc_fetch_unit_if #(parameter int WIDTH = 32);
   logic [WIDTH-1:0] pc;
   logic             pc_valid;
   logic             pc_ready;

   modport master (output pc, output pc_valid, input pc_ready);
   modport slave  (input pc, input pc_valid, output pc_ready);
endinterface

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC selection; kept standalone so a branch predictor can
// reuse it.
module npc_calc
   import pc_defs::*;
#(
   parameter int WIDTH = 32,
   parameter int IMM_W = 16,
   parameter int TGT_W = 26
) (
   input  logic [WIDTH-1:0] pc,
   input  logic [1:0]       npc_sel,
   input  logic             br_taken,
   input  logic [IMM_W-1:0] imm,
   input  logic [TGT_W-1:0] target,
   input  logic [WIDTH-1:0] rs_val,
   output logic [WIDTH-1:0] npc,
   output logic             misaligned
);
   logic [WIDTH-1:0] p4;
   logic [WIDTH-1:0] br_off;

   assign p4     = pc + WIDTH'(4);
   // Word offset: sign-extend to full width first, then scale to bytes.
   assign br_off = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} << 2;

   always_comb begin
      npc = p4;
      unique case (npc_sel)
         NPC_SEQ: npc = p4;
         NPC_BR:  npc = br_taken ? p4 + br_off : p4;
         NPC_J:   npc = {p4[WIDTH-1:TGT_W+2], target, 2'b00};
         NPC_JR:  npc = rs_val;
         default: npc = p4;
      endcase
   end

   assign misaligned = (npc_sel == NPC_JR) && (rs_val[1:0] != 2'b00);
endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter with valid/ready fetch handshake, link capture, sticky
// misaligned-JR fault, halt, and accepted-fetch counter.
module pc_fetch_unit
   import pc_defs::*;
#(
   parameter int          WIDTH     = 32,
   parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
   parameter int          IMM_W     = 16,
   parameter int          TGT_W     = 26,
   parameter int          CNT_W     = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         npc_sel,
   input  logic               br_taken,
   input  logic [IMM_W-1:0]   imm,
   input  logic [TGT_W-1:0]   target,
   input  logic [WIDTH-1:0]   rs_val,
   input  logic               link,
   input  logic               stall,
   input  logic               halt,
   pc_fetch_unit_if.master    fetch,
   output logic [WIDTH-1:0]   link_pc,
   output logic               fault,
   output logic [WIDTH-1:0]   fault_addr,
   output logic [CNT_W-1:0]   fetch_cnt,
   output logic [1:0]         state
);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, npc;
   logic             misaligned, accept, fault_hit;

   npc_calc #(.WIDTH(WIDTH), .IMM_W(IMM_W), .TGT_W(TGT_W)) u_npc (
      .pc         (pc_q),
      .npc_sel    (npc_sel),
      .br_taken   (br_taken),
      .imm        (imm),
      .target     (target),
      .rs_val     (rs_val),
      .npc        (npc),
      .misaligned (misaligned)
   );

   assign accept    = (state_q == ST_RUN) & fetch.pc_valid & fetch.pc_ready;
   assign fault_hit = accept & misaligned;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_BOOT;
      else       state_q <= state_d;
   end

   // Fault outranks halt; HALT and FAULT are left only through reset.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (fault_hit) state_d = ST_FAULT;
            else if (halt) state_d = ST_HALT;
         end
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      fetch.pc_valid = (state_q == ST_RUN) & ~stall;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= WIDTH'(RESET_VEC);
         link_pc    <= '0;
         fault      <= 1'b0;
         fault_addr <= '0;
         fetch_cnt  <= '0;
      end else if (fault_hit) begin
         fault      <= 1'b1;
         fault_addr <= rs_val;
      end else if (accept) begin
         pc_q      <= npc;
         fetch_cnt <= fetch_cnt + CNT_W'(1);
         if (link) link_pc <= pc_q + WIDTH'(4);
      end
   end

   assign fetch.pc = pc_q;
   assign state    = state_q;
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised program-counter and next-PC unit. It is the successor to the single-mode PC register/branch pair. It generates the fetch address for instruction memory using a valid/ready handshake, with stall support. It selects among sequential, conditional-branch, pseudo-direct jump and jump-register next-PC modes, captures a link address, detects misaligned register targets, and counts retired fetches. It sits between the control unit/ALU branch compare and the instruction memory port.

Parameters:
WIDTH, 32, PC/address width; must be >= TGT_W+3
RESET_VEC, 32'h0040_0020, PC value loaded on reset (truncated to WIDTH)
IMM_W, 16, branch offset width (word offset, sign-extended)
TGT_W, 26, jump target field width (word index)
CNT_W, 32, fetch counter width

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
npc_sel  in  2  00 seq, 01 branch, 10 jump, 11 jump-register
br_taken  in  1  branch condition; used only when npc_sel=01
imm  in  IMM_W  signed word offset for branches
target  in  TGT_W  jump word index
rs_val  in  WIDTH  jump-register target
link  in  1  capture return address on this fetch
stall  in  1  hold PC (pipeline hazard)
halt  in  1  request stop
pc_ready  in  1  instruction memory accepts pc
pc  out  WIDTH  current fetch address
pc_valid  out  1  pc is a valid fetch request
link_pc  out  WIDTH  last captured return address
fault  out  1  misaligned jump-register target detected
fault_addr  out  WIDTH  offending target
fetch_cnt  out  CNT_W  number of accepted fetches
state  out  2  FSM state (debug)

Behaviour:
- Clocking and reset: single clock. reset is synchronous and active-high, and takes priority over everything in any state.
- Reset values: pc=RESET_VEC, state=BOOT, pc_valid=0, link_pc=0, fault=0, fault_addr=0, fetch_cnt=0.
- States: BOOT=0, RUN=1, HALT=2, FAULT=3.
- BOOT: pc_valid=0. Moves to RUN after exactly one cycle, so the first valid request appears in cycle 2 after reset deasserts.
- RUN: pc_valid=1 unless stall=1 (pc_valid=!stall).
- accept = (state==RUN) & pc_valid & pc_ready.
- On accept:
  - pc <= npc.
  - fetch_cnt <= fetch_cnt+1, wrapping modulo 2^CNT_W.
  - If link=1, link_pc <= pc+4.
- No accept (stall, or pc_ready=0): pc, link_pc and fetch_cnt hold. The same request stays presented; the request is never dropped.
- npc is computed from the current pc with p4 = pc+4, modulo 2^WIDTH (wrap, no fault):
  - 00: p4.
  - 01: br_taken ? p4 + (sext(imm)<<2) : p4. Offset is sign-extended to WIDTH before the shift; the sum wraps.
  - 10: {p4[WIDTH-1:TGT_W+2], target, 2'b00}.
  - 11: rs_val.
- Misaligned jump-register: npc_sel=11 with rs_val[1:0]!=0 on an accept.
  - pc does not update and fetch_cnt does not increment.
  - fault <= 1, fault_addr <= rs_val, state <= FAULT.
- FAULT: pc_valid=0 and fault stays 1 (sticky). Only reset exits this state.
- halt:
  - Sampled in RUN. If halt=1 together with an accept, the accept completes (pc updates) and then state <= HALT.
  - If halt=1 without an accept, state <= HALT with pc held.
- HALT: pc_valid=0, all registers hold. Only reset exits; halt is ignored in other states.
- Simultaneous halt and misaligned fault: fault wins (state <= FAULT).
- Inputs other than clk/reset are don't-care outside RUN.
- No combinational path from pc_ready to pc. pc_valid depends combinationally only on state and stall.

Decomposition:
- Shared package/header `pc_defs`:
  - npc_sel encodings NPC_SEQ/NPC_BR/NPC_J/NPC_JR.
  - State encodings ST_BOOT/ST_RUN/ST_HALT/ST_FAULT.
  - Default RESET_VEC.
- One combinational sub-module, `npc_calc` (pc, npc_sel, br_taken, imm, target, rs_val -> npc, misaligned). It is reusable by a later branch-prediction block.
- The FSM, registers and counter live in the top module.

Test Plan:
1. Reset then free-run with pc_ready=1, npc_sel=00 -> pc_valid=0 for 1 cycle; pc sequence 0x00400020, 0x00400024, 0x00400028; fetch_cnt=3 after 3 accepts.
2. pc=0x00400030, npc_sel=01, imm=16'hFFFE: br_taken=1 -> pc=0x0040002C; br_taken=0 -> pc=0x00400034.
3. pc=0x00400040, npc_sel=10, target=26'h0100010, link=1 -> pc=0x00400040, link_pc=0x00400044. Then pc=0xFFFFFFFC with npc_sel=00 -> pc=0x00000000 (wrap, no fault).
4. Stall held 3 cycles and pc_ready=0 for 2 cycles mid-run -> pc and fetch_cnt unchanged throughout; pc_valid=0 only while stall=1; resumes with the same pc.
5. npc_sel=11, rs_val=0x00400102 -> fault=1, fault_addr=0x00400102, pc unchanged, pc_valid=0. Then reset pulse -> all outputs return to their reset values.
6. halt=1 coincident with an accept (pc=0x00400050) -> pc=0x00400054, then state=HALT, pc_valid=0. With halt+stall in RUN -> pc held and state=HALT.
